argmax_topk_cell: RTL and testbench

- Streaming top-K argmax for the classifier output stage. It sits after the final dense layer.
- Each frame is CLASS_COUNT scores, accepted one per cycle over a valid/ready handshake. The cell keeps a sorted list of the K best scores and their indices.
- At frame end it presents the list as one registered result with valid/ready.
- Compared with the single-winner cell, it adds: top-K instead of one winner, an internal index counter, signed/unsigned compare, selectable tie-break, early frame termination, and back-pressure.

---
 rtl/argmax_topk_cell.sv | 141 ++++++++++++++
 tb/tb_argmax_topk_cell.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/argmax_topk_cell.sv
// Streaming top-K argmax: keeps a sorted list of the K best scores of a frame
// and presents it as one registered result with valid/ready back-pressure.
module argmax_topk_cell #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned INDEX_WIDTH = 8,
   parameter int unsigned CLASS_COUNT = 10,
   parameter int unsigned TOP_K       = 3,
   parameter int unsigned SIGNED_CMP  = 0,
   parameter int unsigned TIE_LAST    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_WIDTH-1:0]          in_value,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [TOP_K*INDEX_WIDTH-1:0]   out_indices,
   output logic [TOP_K*DATA_WIDTH-1:0]    out_values,
   output logic [TOP_K-1:0]               out_slot_valid,
   output logic [INDEX_WIDTH-1:0]         out_count
);

   typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

   state_t                        r_state;
   logic [DATA_WIDTH-1:0]         r_val [TOP_K];
   logic [INDEX_WIDTH-1:0]        r_idx [TOP_K];
   logic [TOP_K-1:0]              r_sv;
   logic [INDEX_WIDTH-1:0]        r_cnt;
   logic                          r_out_valid;
   logic [TOP_K*INDEX_WIDTH-1:0]  r_out_idx;
   logic [TOP_K*DATA_WIDTH-1:0]   r_out_val;
   logic [TOP_K-1:0]              r_out_sv;
   logic [INDEX_WIDTH-1:0]        r_out_cnt;

   logic                          w_accept;
   logic                          w_frame_end;
   logic [DATA_WIDTH-1:0]         w_nval [TOP_K];
   logic [INDEX_WIDTH-1:0]        w_nidx [TOP_K];
   logic [TOP_K-1:0]              w_nsv;
   logic                          w_gt;
   logic                          w_eq;
   logic                          w_beat;
   logic                          w_prev_beat;
   logic [DATA_WIDTH-1:0]         w_pval;
   logic [INDEX_WIDTH-1:0]        w_pidx;
   logic                          w_psv;

   assign in_ready    = !(r_out_valid && !out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_frame_end = w_accept && (in_last || (r_cnt == INDEX_WIDTH'(CLASS_COUNT - 1)));

   // The list is sorted, so the "beats" vector is monotonic: the first slot
   // beaten takes the new entry and every later beaten slot takes its predecessor.
   always_comb begin
      w_gt        = 1'b0;
      w_eq        = 1'b0;
      w_beat      = 1'b0;
      w_prev_beat = 1'b0;
      w_pval      = '0;
      w_pidx      = '1;
      w_psv       = 1'b0;
      w_nsv       = r_sv;
      for (int k = 0; k < int'(TOP_K); k++) begin
         w_nval[k] = r_val[k];
         w_nidx[k] = r_idx[k];
         if (SIGNED_CMP != 0) w_gt = $signed(in_value) > $signed(r_val[k]);
         else                 w_gt = in_value > r_val[k];
         w_eq   = (in_value == r_val[k]);
         w_beat = !r_sv[k] || w_gt || (w_eq && (TIE_LAST != 0));
         if (w_beat && !w_prev_beat) begin
            w_nval[k] = in_value;
            w_nidx[k] = r_cnt;
            w_nsv[k]  = 1'b1;
         end else if (w_beat) begin
            w_nval[k] = w_pval;
            w_nidx[k] = w_pidx;
            w_nsv[k]  = w_psv;
         end
         w_prev_beat = w_beat;
         w_pval      = r_val[k];
         w_pidx      = r_idx[k];
         w_psv       = r_sv[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_ACCUM;
         r_cnt       <= '0;
         r_sv        <= '0;
         r_out_valid <= 1'b0;
         r_out_idx   <= '1;
         r_out_val   <= '0;
         r_out_sv    <= '0;
         r_out_cnt   <= '0;
         for (int k = 0; k < int'(TOP_K); k++) begin
            r_val[k] <= '0;
            r_idx[k] <= '1;
         end
      end else begin
         unique case (r_state)
            ST_ACCUM: if (r_out_valid && !out_ready) r_state <= ST_HOLD;
            ST_HOLD:  if (out_ready)                 r_state <= ST_ACCUM;
            default:                                 r_state <= ST_ACCUM;
         endcase

         if (r_out_valid && out_ready) r_out_valid <= 1'b0;

         if (w_frame_end) begin
            r_cnt       <= '0;
            r_sv        <= '0;
            r_out_valid <= 1'b1;
            r_out_sv    <= w_nsv;
            r_out_cnt   <= r_cnt + INDEX_WIDTH'(1);
            for (int k = 0; k < int'(TOP_K); k++) begin
               r_val[k] <= '0;
               r_idx[k] <= '1;
               r_out_idx[k*INDEX_WIDTH +: INDEX_WIDTH] <= w_nidx[k];
               r_out_val[k*DATA_WIDTH +: DATA_WIDTH]   <= w_nval[k];
            end
         end else if (w_accept) begin
            r_cnt <= r_cnt + INDEX_WIDTH'(1);
            r_sv  <= w_nsv;
            for (int k = 0; k < int'(TOP_K); k++) begin
               r_val[k] <= w_nval[k];
               r_idx[k] <= w_nidx[k];
            end
         end
      end
   end

   assign out_valid      = r_out_valid;
   assign out_indices    = r_out_idx;
   assign out_values     = r_out_val;
   assign out_slot_valid = r_out_sv;
   assign out_count      = r_out_cnt;

endmodule

// File: tb/tb_argmax_topk_cell.sv
// Directed bench for argmax_topk_cell: three instances (tie-last, tie-first,
// signed) share one input stream; results are checked against hand-worked lists.
module tb_argmax_topk_cell;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_value;
   logic        in_last;
   logic        out_ready;

   logic        a_in_ready, b_in_ready, c_in_ready;
   logic        a_out_valid, b_out_valid, c_out_valid;
   logic [23:0] a_idx, b_idx, c_idx;
   logic [95:0] a_val, b_val, c_val;
   logic [2:0]  a_sv, b_sv, c_sv;
   logic [7:0]  a_cnt, b_cnt, c_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   argmax_topk_cell #(.TIE_LAST(1), .SIGNED_CMP(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_value(in_value), .in_last(in_last), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_indices(a_idx), .out_values(a_val),
      .out_slot_valid(a_sv), .out_count(a_cnt));

   argmax_topk_cell #(.TIE_LAST(0), .SIGNED_CMP(0)) dut_t0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_value(in_value), .in_last(in_last), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_indices(b_idx), .out_values(b_val),
      .out_slot_valid(b_sv), .out_count(b_cnt));

   argmax_topk_cell #(.TIE_LAST(1), .SIGNED_CMP(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_value(in_value), .in_last(in_last), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_indices(c_idx), .out_values(c_val),
      .out_slot_valid(c_sv), .out_count(c_cnt));

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one beat, let it be taken at the next rising edge, sample 1 ns later.
   task automatic beat(input logic [31:0] v, input logic l);
      in_valid = 1'b1;
      in_value = v;
      in_last  = l;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] s1 [10];

   initial begin
      s1 = '{32'd5, 32'd9, 32'd2, 32'd9, 32'd7, 32'd1, 32'd0, 32'd3, 32'd8, 32'd4};
      rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_indices",   a_idx, 24'hFFFFFF);
      check("rst_values",    a_val, 0);
      check("rst_slot_valid", a_sv, 0);
      check("rst_count",     a_cnt, 0);
      check("rst_in_ready",  a_in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full frame ended by the counter, ties present
      for (int i = 0; i < 10; i++) beat(s1[i], 1'b0);
      check("f1_out_valid",  a_out_valid, 1);
      check("f1_idx_tlast",  a_idx, 24'h080103);
      check("f1_values",     a_val, 96'h00000008_00000009_00000009);
      check("f1_count",      a_cnt, 10);
      check("f1_slot_valid", a_sv, 3'b111);
      check("f1_idx_tfirst", b_idx, 24'h080301);

      // Short frame back-to-back; first beat consumes the previous result
      beat(32'd4, 1'b0);
      check("short_mid_valid", a_out_valid, 0);
      beat(32'd6, 1'b1);
      check("short_valid",  a_out_valid, 1);
      check("short_idx",    a_idx, 24'hFF0001);
      check("short_values", a_val, 96'h00000000_00000004_00000006);
      check("short_sv",     a_sv, 3'b011);
      check("short_count",  a_cnt, 2);

      // Signed vs unsigned compare on the same stream
      beat(32'hFFFFFFFF, 1'b0);
      beat(32'hFFFFFFFB, 1'b0);
      beat(32'h7FFFFFFF, 1'b0);
      beat(32'hFFFFFFFE, 1'b1);
      check("sgn_idx_signed",   c_idx, 24'h030002);
      check("sgn_idx_unsigned", a_idx, 24'h010300);
      check("sgn_count",        c_cnt, 4);
      in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk);
      #1;
      check("idle_consumed", a_out_valid, 0);

      // Back-pressure: result A held while the producer keeps offering a beat
      out_ready = 1'b0;
      beat(32'd1, 1'b0);
      beat(32'd2, 1'b0);
      beat(32'd3, 1'b1);
      check("bpA_valid", a_out_valid, 1);
      check("bpA_idx",   a_idx, 24'h000102);
      in_value = 32'd100; in_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", a_in_ready, 0);
         @(posedge clk);
         #1;
         check("bp_hold_valid", a_out_valid, 1);
         check("bp_hold_idx",   a_idx, 24'h000102);
         check("bp_hold_count", a_cnt, 3);
      end
      in_value  = 32'd10;
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", a_in_ready, 1);
      beat(32'd10, 1'b0);
      check("bpB_mid_valid", a_out_valid, 0);
      beat(32'd20, 1'b1);
      check("bpB_idx",    a_idx, 24'hFF0001);
      check("bpB_values", a_val, 96'h00000000_0000000A_00000014);
      check("bpB_count",  a_cnt, 2);

      // Single-beat frame accepted while result B is consumed
      beat(32'd50, 1'b1);
      check("one_valid",  a_out_valid, 1);
      check("one_idx",    a_idx, 24'hFFFF00);
      check("one_values", a_val, 96'h00000000_00000000_00000032);
      check("one_sv",     a_sv, 3'b001);
      check("one_count",  a_cnt, 1);

      // Two full frames streamed without gaps
      for (int i = 0; i < 10; i++) beat(s1[i], 1'b0);
      check("cont1_idx",   a_idx, 24'h080103);
      check("cont1_count", a_cnt, 10);
      for (int i = 0; i < 10; i++) beat(32'(10 * i), 1'b0);
      check("cont2_valid",  a_out_valid, 1);
      check("cont2_idx",    a_idx, 24'h070809);
      check("cont2_values", a_val, 96'h00000046_00000050_0000005A);
      check("cont2_count",  a_cnt, 10);

      // Reset while beat 4 of a frame is on the bus
      beat(32'd100, 1'b0);
      beat(32'd200, 1'b0);
      beat(32'd300, 1'b0);
      beat(32'd400, 1'b0);
      in_value = 32'd500;
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", a_out_valid, 0);
      check("mrst_idx",   a_idx, 24'hFFFFFF);
      check("mrst_count", a_cnt, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      beat(32'd3, 1'b0); beat(32'd1, 1'b0); beat(32'd4, 1'b0); beat(32'd1, 1'b0);
      beat(32'd5, 1'b0); beat(32'd9, 1'b0); beat(32'd2, 1'b0); beat(32'd6, 1'b0);
      beat(32'd5, 1'b0); beat(32'd3, 1'b0);
      check("post_valid",      a_out_valid, 1);
      check("post_idx",        a_idx, 24'h080705);
      check("post_values",     a_val, 96'h00000005_00000006_00000009);
      check("post_count",      a_cnt, 10);
      check("post_idx_tfirst", b_idx, 24'h040705);
      in_valid = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
